// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath: multiplicand/multiplier/product registers driven by select lines from a control FSM.
// Optional MULT_DONE_FLAG_EN adds an iteration counter and oDone flag.
module mult_datapath #(
    parameter int WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    input  logic                 iA_Sel,
    input  logic                 iB_Sel,
    input  logic                 iProduct_Sel,
    input  logic                 iAdd_Sel,
    input  logic                 iShift,
    output logic                 oLSB,
    output logic                 oZero,
    output logic [2*WIDTH-1:0]   oProduct
`ifdef MULT_DONE_FLAG_EN
    ,
    output logic                 oDone
`endif
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    rA;
    logic [WIDTH-1:0] rB;
    logic [PW-1:0]    rP;

    // Multiplicand lives in a double-width register so shifted bits land in the upper half.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            rA <= '0;
        else if (iA_Sel)
            rA <= {{WIDTH{1'b0}}, iA};
        else if (iShift)
            rA <= {rA[PW-2:0], 1'b0};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            rB <= '0;
        else if (iB_Sel)
            rB <= iB;
        else if (iShift)
            rB <= {1'b0, rB[WIDTH-1:1]};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            rP <= '0;
        else if (iProduct_Sel)
            rP <= '0;
        else if (iAdd_Sel)
            rP <= rP + rA;
    end

    assign oLSB     = rB[0];
    assign oZero    = (rB == '0);
    assign oProduct = rP;

`ifdef MULT_DONE_FLAG_EN
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [CW-1:0] rCnt;

    // Saturates so extra shifts after completion keep oDone asserted.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            rCnt <= '0;
        else if (iB_Sel)
            rCnt <= '0;
        else if (iShift && (rCnt != CNT_MAX))
            rCnt <= rCnt + 1'b1;
    end

    assign oDone = (rCnt == CNT_MAX);
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Directed self-checking bench for mult_datapath (WIDTH=16); exercises the done flag when MULT_DONE_FLAG_EN is defined.
module tb_mult_datapath;

    localparam int WIDTH = 16;

    logic               Clock = 1'b0;
    logic               Reset = 1'b0;
    logic [WIDTH-1:0]   iA = '0;
    logic [WIDTH-1:0]   iB = '0;
    logic               iA_Sel = 1'b0;
    logic               iB_Sel = 1'b0;
    logic               iProduct_Sel = 1'b0;
    logic               iAdd_Sel = 1'b0;
    logic               iShift = 1'b0;
    logic               oLSB;
    logic               oZero;
    logic [2*WIDTH-1:0] oProduct;
`ifdef MULT_DONE_FLAG_EN
    logic               oDone;
`endif

    int total = 0;
    int bad = 0;

    mult_datapath #(.WIDTH(WIDTH)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iA(iA),
        .iB(iB),
        .iA_Sel(iA_Sel),
        .iB_Sel(iB_Sel),
        .iProduct_Sel(iProduct_Sel),
        .iAdd_Sel(iAdd_Sel),
        .iShift(iShift),
        .oLSB(oLSB),
        .oZero(oZero),
        .oProduct(oProduct)
`ifdef MULT_DONE_FLAG_EN
        ,
        .oDone(oDone)
`endif
    );

    always #5 Clock = ~Clock;

    // One clock edge with the currently driven selects, then release them.
    task automatic step();
        @(posedge Clock);
        #1;
        iA_Sel = 1'b0;
        iB_Sel = 1'b0;
        iProduct_Sel = 1'b0;
        iAdd_Sel = 1'b0;
        iShift = 1'b0;
    endtask

    task automatic load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        iA = a;
        iB = b;
        iA_Sel = 1'b1;
        iB_Sel = 1'b1;
        iProduct_Sel = 1'b1;
        step();
    endtask

    // Control-machine behaviour: add when the multiplier LSB is set, then shift.
    task automatic iterate();
        if (oLSB) begin
            iAdd_Sel = 1'b1;
            step();
        end
        iShift = 1'b1;
        step();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #1;
        total++;
        if ({oLSB, oZero, oProduct} !== {1'b0, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL reset_async lsb/zero/prod got %b/%b/%h want 0/1/00000000", oLSB, oZero, oProduct);
        end
        iA = 16'h1234; iB = 16'h5555;
        iA_Sel = 1'b1; iB_Sel = 1'b1; iAdd_Sel = 1'b1; iShift = 1'b1;
        step();
        step();
        total++;
        if ({oLSB, oZero, oProduct} !== {1'b0, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL reset_hold lsb/zero/prod got %b/%b/%h want 0/1/00000000", oLSB, oZero, oProduct);
        end
`ifdef MULT_DONE_FLAG_EN
        total++;
        if (oDone !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got %b want 0", oDone);
        end
`endif
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        load(16'd3, 16'd5);
        total++;
        if ({oLSB, oZero, oProduct} !== {1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL basic_load lsb/zero/prod got %b/%b/%h want 1/0/00000000", oLSB, oZero, oProduct);
        end
        for (int i = 1; i <= WIDTH; i++) begin
            iterate();
            if (i == 1) begin
                total++;
                if (oProduct !== 32'd3) begin
                    bad++;
                    $display("FAIL basic_iter1 prod got %0d want 3", oProduct);
                end
            end
            if (i == 2) begin
                total++;
                if (oZero !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_zero2 got %b want 0", oZero);
                end
            end
            if (i == 3) begin
                total++;
                if (oZero !== 1'b1) begin
                    bad++;
                    $display("FAIL basic_zero3 got %b want 1", oZero);
                end
            end
        end
        total++;
        if (oProduct !== 32'd15) begin
            bad++;
            $display("FAIL basic_product got %0d want 15", oProduct);
        end
    endtask

    task automatic test_max();
        load(16'hFFFF, 16'hFFFF);
        for (int i = 0; i < WIDTH; i++) iterate();
        total++;
        if (oProduct !== 32'hFFFE0001) begin
            bad++;
            $display("FAIL max_product got %h want fffe0001", oProduct);
        end
        total++;
        if (oZero !== 1'b1) begin
            bad++;
            $display("FAIL max_zero got %b want 1", oZero);
        end
    endtask

    task automatic test_priority();
        iProduct_Sel = 1'b1;
        step();
        iA = 16'd7; iA_Sel = 1'b1; iShift = 1'b1;
        iB = 16'd6; iB_Sel = 1'b1;
        step();
        total++;
        if ({oLSB, oZero} !== 2'b00) begin
            bad++;
            $display("FAIL prio_bload lsb/zero got %b/%b want 0/0", oLSB, oZero);
        end
        iAdd_Sel = 1'b1;
        step();
        total++;
        if (oProduct !== 32'd7) begin
            bad++;
            $display("FAIL prio_aload prod got %0d want 7", oProduct);
        end
        iProduct_Sel = 1'b1; iAdd_Sel = 1'b1;
        step();
        total++;
        if (oProduct !== 32'd0) begin
            bad++;
            $display("FAIL prio_clear prod got %0d want 0", oProduct);
        end
    endtask

    task automatic test_add_shift();
        load(16'd4, 16'd0);
        iAdd_Sel = 1'b1; iShift = 1'b1;
        step();
        total++;
        if (oProduct !== 32'd4) begin
            bad++;
            $display("FAIL addshift_sum got %0d want 4", oProduct);
        end
        iAdd_Sel = 1'b1;
        step();
        total++;
        if (oProduct !== 32'd12) begin
            bad++;
            $display("FAIL addshift_shifted got %0d want 12", oProduct);
        end
    endtask

    task automatic test_async_reset();
        load(16'h00FF, 16'h0101);
        for (int i = 0; i < 7; i++) iterate();
        total++;
        if (oProduct !== 32'h00FF) begin
            bad++;
            $display("FAIL areset_partial got %h want 000000ff", oProduct);
        end
        iShift = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        total++;
        if ({oLSB, oZero, oProduct} !== {1'b0, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL areset_now lsb/zero/prod got %b/%b/%h want 0/1/00000000", oLSB, oZero, oProduct);
        end
        step();
        Reset = 1'b0;
        #1;
        load(16'd2, 16'd3);
        for (int i = 0; i < WIDTH; i++) iterate();
        total++;
        if (oProduct !== 32'd6) begin
            bad++;
            $display("FAIL areset_fresh got %0d want 6", oProduct);
        end
    endtask

`ifdef MULT_DONE_FLAG_EN
    task automatic test_done_flag();
        iB = 16'h0000; iB_Sel = 1'b1;
        step();
        for (int i = 1; i <= WIDTH + 1; i++) begin
            iShift = 1'b1;
            step();
            if (i == WIDTH - 1) begin
                total++;
                if (oDone !== 1'b0) begin
                    bad++;
                    $display("FAIL done_early got %b want 0", oDone);
                end
            end
            if (i >= WIDTH) begin
                total++;
                if (oDone !== 1'b1) begin
                    bad++;
                    $display("FAIL done_shift%0d got %b want 1", i, oDone);
                end
            end
        end
        iB_Sel = 1'b1;
        step();
        total++;
        if (oDone !== 1'b0) begin
            bad++;
            $display("FAIL done_clear got %b want 0", oDone);
        end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_basic();
        test_max();
        test_priority();
        test_add_shift();
        test_async_reset();
`ifdef MULT_DONE_FLAG_EN
        test_done_flag();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
